// File: rtl/alu_uart_if.sv
// -----------------------------------------------------------------------------
// alu_uart_if
//
// Sequencer between a byte-wide UART receiver/transmitter pair and a
// combinational ALU. A frame is three received bytes (operand A, operand B,
// opcode). Once the opcode arrives the ALU is given one cycle to settle, its
// result and flags are latched, and two bytes are sent back: result, then
// flags. A frame that stalls between bytes is abandoned after TIMEOUT cycles.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_data/valid   received byte and its one-cycle strobe
//   tx_done         transmitter finished the current byte (one-cycle pulse)
//   tx_data/start   byte to transmit and its one-cycle request strobe
//   alu_a/b/op      registered ALU operands and opcode
//   alu_y, alu_*    ALU result and flags (carry, borrow, overflow, zero, neg)
//   busy            high whenever a frame is in progress
//   overrun         sticky: a byte arrived while a response was in flight
//   timeout         one-cycle pulse when a partial frame is abandoned
// -----------------------------------------------------------------------------
module alu_uart_if #(
    parameter int W       = 8,
    parameter int WOP     = 6,
    parameter int TIMEOUT = 1000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    input  logic           tx_done,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [WOP-1:0] alu_op,
    input  logic [W-1:0]   alu_y,
    input  logic           alu_carry,
    input  logic           alu_borrow,
    input  logic           alu_overflow,
    input  logic           alu_zero,
    input  logic           alu_neg,
    output logic           busy,
    output logic           overrun,
    output logic           timeout
);

    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_Y, WAIT_Y, SEND_F, WAIT_F
    } state_t;

    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [WOP-1:0] op_q, op_d;
    logic [7:0]     tx_q, tx_d;
    logic [4:0]     flags_q, flags_d;
    logic [CW-1:0]  gap_q, gap_d;
    logic           ovr_q, ovr_d;
    logic           to_q, to_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tx_d    = tx_q;
        flags_d = flags_q;
        gap_d   = gap_q;
        ovr_d   = ovr_q;
        to_d    = 1'b0;

        case (state_q)
            WAIT_A: begin
                if (rx_valid) begin
                    a_d     = rx_data[W-1:0];
                    gap_d   = '0;
                    state_d = WAIT_B;
                end
            end
            WAIT_B, WAIT_OP: begin
                // A byte arriving on the expiry cycle is still accepted.
                if (rx_valid) begin
                    gap_d = '0;
                    if (state_q == WAIT_B) begin
                        b_d     = rx_data[W-1:0];
                        state_d = WAIT_OP;
                    end else begin
                        op_d    = rx_data[WOP-1:0];
                        state_d = EXEC;
                    end
                end else if (gap_q == TMAX) begin
                    gap_d   = '0;
                    to_d    = 1'b1;
                    state_d = WAIT_A;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            EXEC: begin
                // Operands were registered on the previous edge, so the ALU
                // outputs have had a full cycle to settle.
                tx_d    = alu_y;
                flags_d = {alu_neg, alu_zero, alu_overflow, alu_borrow, alu_carry};
                state_d = SEND_Y;
            end
            SEND_Y: state_d = WAIT_Y;
            WAIT_Y: begin
                if (tx_done) begin
                    tx_d    = {3'b000, flags_q};
                    state_d = SEND_F;
                end
            end
            SEND_F: state_d = WAIT_F;
            WAIT_F: begin
                if (tx_done) state_d = WAIT_A;
            end
            default: state_d = WAIT_A;
        endcase

        // Bytes arriving while a response is pending are dropped, not queued.
        if (rx_valid && (state_q inside {EXEC, SEND_Y, WAIT_Y, SEND_F, WAIT_F}))
            ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tx_q    <= '0;
            gap_q   <= '0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
            gap_q   <= gap_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    // Flags are always rewritten in EXEC before being read, so no reset.
    always_ff @(posedge clk) begin
        flags_q <= flags_d;
    end

    assign tx_data  = tx_q;
    assign tx_start = (state_q == SEND_Y) || (state_q == SEND_F);
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign busy     = (state_q != WAIT_A);
    assign overrun  = ovr_q;
    assign timeout  = to_q;

endmodule

// File: tb/tb_alu_uart_if.sv
module tb_alu_uart_if;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] alu_a, alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_y;
    logic       alu_carry, alu_borrow, alu_overflow, alu_zero, alu_neg;
    logic       busy, overrun, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_uart_if #(.W(8), .WOP(6), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_done(tx_done),
        .tx_data(tx_data), .tx_start(tx_start),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_carry(alu_carry), .alu_borrow(alu_borrow),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    // Stand-in ALU: 0x20 add, 0x22 sub, 0x25 or, anything else yields 0.
    logic [8:0] sum;
    always_comb begin
        sum          = 9'd0;
        alu_y        = 8'h00;
        alu_carry    = 1'b0;
        alu_borrow   = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            6'h20: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y        = sum[7:0];
                alu_carry    = sum[8];
                alu_overflow = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
            end
            6'h22: begin
                alu_y        = alu_a - alu_b;
                alu_borrow   = alu_a < alu_b;
                alu_overflow = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
            end
            6'h25: alu_y = alu_a | alu_b;
            default: alu_y = 8'h00;
        endcase
        alu_zero = (alu_y == 8'h00);
        alu_neg  = alu_y[7];
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp_y;
        logic [7:0] exp_f;
        logic [5:0] exp_op;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Returns with tx_start high, or flags a failure after a bounded wait.
    task automatic wait_tx_start(input string name, output bit ok);
        int k;
        ok = 1'b0;
        for (k = 0; k < 50; k++) begin
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: tx_start never rose (got 0 expected 1)", name);
        end
    endtask

    // Runs one complete frame; optionally injects a stray byte during WAIT_Y.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input bit inject, output logic [7:0] y, output logic [7:0] f);
        bit ok;
        y = 8'hxx;
        f = 8'hxx;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_tx_start("tx_start_y", ok);
        if (!ok) return;
        y = tx_data;
        tick();
        if (inject) begin
            send_byte(8'h99);
            check("overrun_set", overrun, 1);
        end
        repeat (8) tick();
        pulse_tx_done();
        wait_tx_start("tx_start_f", ok);
        if (!ok) return;
        f = tx_data;
        tick();
        repeat (9) tick();
        pulse_tx_done();
    endtask

    initial begin
        logic [7:0] y, f;
        bit seen;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 6'h20};
        vecs[1] = '{8'h03, 8'h05, 8'h22, 8'hFE, 8'h12, 6'h22};
        vecs[2] = '{8'h7F, 8'h01, 8'h20, 8'h80, 8'h14, 6'h20};
        vecs[3] = '{8'hFF, 8'h01, 8'h20, 8'h00, 8'h09, 6'h20};
        vecs[4] = '{8'h01, 8'h02, 8'h25, 8'h03, 8'h00, 6'h25};
        vecs[5] = '{8'h12, 8'h34, 8'h3F, 8'h00, 8'h08, 6'h3F};
        vecs[6] = '{8'h10, 8'h20, 8'hE0, 8'h30, 8'h00, 6'h20};

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);

        foreach (vecs[i]) begin
            run_frame(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, y, f);
            check($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
            check($sformatf("vec%0d_f", i), f, vecs[i].exp_f);
            check($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].a);
            check($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].b);
            check($sformatf("vec%0d_alu_op", i), alu_op, vecs[i].exp_op);
            check($sformatf("vec%0d_busy_end", i), busy, 0);
            tick();
        end
        check("no_overrun_yet", overrun, 0);

        // tx_start latency and pulse width
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h20);
        check("lat_exec_start", tx_start, 0);
        check("lat_exec_busy", busy, 1);
        tick();
        check("lat_start_high", tx_start, 1);
        check("lat_tx_y", tx_data, 8'h00);
        tick();
        check("lat_start_low", tx_start, 0);
        repeat (3) tick();
        pulse_tx_done();
        check("lat_start_f", tx_start, 1);
        check("lat_tx_f", tx_data, 8'h09);
        tick();
        pulse_tx_done();
        check("lat_idle", busy, 0);
        tick();

        // Partial frame timeout
        send_byte(8'h05);
        repeat (14) tick();
        check("to_early", timeout, 0);
        tick();
        check("to_before", timeout, 0);
        check("to_busy_before", busy, 1);
        tick();
        check("to_pulse", timeout, 1);
        check("to_busy", busy, 0);
        check("to_keep_a", alu_a, 8'h05);
        tick();
        check("to_single", timeout, 0);
        run_frame(8'h01, 8'h02, 8'h25, 1'b0, y, f);
        check("to_next_y", y, 8'h03);
        check("to_next_f", f, 8'h00);
        tick();

        // Byte arriving at the expiry cycle is accepted
        send_byte(8'h40);
        repeat (15) tick();
        send_byte(8'h02);
        check("edge_no_to", timeout, 0);
        check("edge_alu_b", alu_b, 8'h02);
        send_byte(8'h20);
        tick();
        check("edge_tx_y", tx_data, 8'h42);
        tick();
        pulse_tx_done();
        tick();
        pulse_tx_done();
        check("edge_idle", busy, 0);
        tick();

        // Overrun during WAIT_Y
        run_frame(8'h05, 8'h03, 8'h20, 1'b1, y, f);
        check("ovr_y", y, 8'h08);
        check("ovr_f", f, 8'h00);
        check("ovr_sticky", overrun, 1);
        tick();
        run_frame(8'h03, 8'h05, 8'h22, 1'b0, y, f);
        check("ovr_next_y", y, 8'hFE);
        check("ovr_next_f", f, 8'h12);
        check("ovr_still", overrun, 1);

        // Reset during WAIT_Y
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(8'h20);
        tick();
        tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_tx_start", tx_start, 0);
        check("mrst_tx_data", tx_data, 8'h00);
        check("mrst_alu_a", alu_a, 8'h00);
        check("mrst_alu_b", alu_b, 8'h00);
        check("mrst_alu_op", alu_op, 6'h00);
        check("mrst_overrun", overrun, 0);
        check("mrst_timeout", timeout, 0);
        pulse_tx_done();
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (tx_start === 1'b1 || busy === 1'b1) seen = 1'b1;
            tick();
        end
        check("mrst_stray_done", seen, 0);
        run_frame(8'h7F, 8'h01, 8'h20, 1'b0, y, f);
        check("mrst_next_y", y, 8'h80);
        check("mrst_next_f", f, 8'h14);
        check("mrst_next_ovr", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (got hang expected finish)");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/alu_uart_if.md
Name: alu_uart_if

Overview:
- Sequencer between the UART receiver/transmitter and the combinational ALU.
- Collects three received bytes in order (operand A, operand B, opcode) and drives them to the ALU.
- Captures the ALU result and flags, then transmits two bytes back: result, then flags.
- Top-level glue for UART-based ALU bring-up; the ALU's A/B/op inputs are fed only from this block.

Parameters:
- W, 8, data width of A/B/Y; must equal 8 (one UART byte per operand).
- WOP, 6, opcode width; opcode is rx_data[WOP-1:0]; upper rx bits are ignored.
- TIMEOUT, 1000000, clk cycles allowed between bytes of one frame before the frame is abandoned; minimum 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle pulse: rx_data valid this cycle.
- tx_done  in  1  one-cycle pulse: transmitter finished current byte.
- tx_data  out  8  byte to transmit, registered.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- alu_a  out  W  operand A to ALU, registered.
- alu_b  out  W  operand B to ALU, registered.
- alu_op  out  WOP  opcode to ALU, registered.
- alu_y  in  W  ALU result.
- alu_carry, alu_borrow, alu_overflow, alu_zero, alu_neg  in  1 each  ALU flags.
- busy  out  1  high in any state other than WAIT_A.
- overrun  out  1  sticky: an rx_valid pulse arrived while sending; cleared only by rst.
- timeout  out  1  one-cycle pulse when a partial frame is abandoned.

Behaviour:
- Reset (rst=1 at clk edge) forces the following, taking priority over everything including mid-transmission:
  - state=WAIT_A; alu_a=alu_b=0; alu_op=0; tx_data=0.
  - tx_start=0, busy=0, overrun=0, timeout=0; gap counter=0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_Y, WAIT_Y, SEND_F, WAIT_F.
- WAIT_A: on rx_valid, alu_a<=rx_data, gap counter cleared, go WAIT_B.
- WAIT_B: on rx_valid, alu_b<=rx_data, gap counter cleared, go WAIT_OP.
- WAIT_OP: on rx_valid, alu_op<=rx_data[WOP-1:0], go EXEC.
- Timeout in WAIT_B/WAIT_OP:
  - Gap counter increments each cycle without rx_valid.
  - When it reaches TIMEOUT-1 without rx_valid: return to WAIT_A, pulse timeout for one cycle.
  - alu_a/alu_b/alu_op keep their values.
  - rx_valid on the same cycle as expiry wins: the byte is accepted and there is no timeout.
- EXEC (exactly 1 cycle, ALU inputs stable from the previous edge):
  - Register the result and flags: tx_data<=alu_y; flag register<={3'b000, neg, zero, overflow, borrow, carry} (carry in bit0).
  - Go SEND_Y.
- SEND_Y: tx_start=1 for exactly this one cycle; go WAIT_Y.
- WAIT_Y: hold tx_data; on tx_done, tx_data<=flag register, go SEND_F.
- SEND_F: tx_start=1 for one cycle; go WAIT_F.
- WAIT_F: on tx_done go WAIT_A.
- Latency: last rx_valid (opcode) at edge N -> EXEC at N+1 -> tx_start high during cycle N+2.
- No timeout while sending; an unanswered transmitter stalls the block until rst.
- rx_valid in EXEC/SEND_*/WAIT_*:
  - The byte is dropped and overrun<=1.
  - Bytes are never queued.
- tx_done seen outside WAIT_Y/WAIT_F is ignored.
- alu_a/alu_b/alu_op change only on their own capture cycles, so ALU outputs are stable from EXEC through the end of transmission.
- Undefined opcodes are passed through unchanged; the response is whatever the ALU returns (0x00 result, flags 0x08).

Test Plan:
- rx 0x05,0x03,0x20 with tx_done 10 cycles after each tx_start -> tx bytes 0x08 then 0x00; busy returns low after second tx_done.
- rx 0x03,0x05,0x22 -> tx 0xFE then 0x12 (borrow, neg); rx 0x7F,0x01,0x20 -> tx 0x80 then 0x14 (overflow, neg).
- rx 0xFF,0x01,0x20 -> tx 0x00 then 0x09 (carry, zero); check tx_start is a single-cycle pulse exactly 2 cycles after the opcode rx_valid.
- TIMEOUT=16: rx 0x05 only, idle -> timeout pulses 16 cycles later, state WAIT_A; then rx 0x01,0x02,0x25 -> tx 0x03, 0x00 (first byte not reused).
- rx_valid pulse during WAIT_Y -> overrun=1 and stays 1; response bytes unchanged; next frame processes normally.
- Assert rst during WAIT_Y -> next cycle all outputs at reset values; a stray tx_done afterwards causes no tx_start; a new frame works.
